// File: rtl/flash_page_loader.sv
// SPI page loader: streams one flash page over single-bit SPI into the page cache SRAM.
// Define FLASH_LOADER_FAST_READ_EN for fast read (0x0B plus 8 dummy clocks) instead of 0x03.
module flash_page_loader #(
  parameter int PAGE_WORDS       = 512,
  parameter int WORD_ADDR_BITS   = 9,
  parameter int SCLK_HALF        = 1,
  parameter int INIT_WAIT_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      start,
  input  logic [23:0]               pageAddress,
  output logic                      initialised,
  output logic                      busy,
  output logic [WORD_ADDR_BITS:0]   loadAddress,
  output logic                      done,
  output logic                      sramWriteEnable,
  output logic [WORD_ADDR_BITS-1:0] sramAddress,
  output logic [31:0]               sramData,
  output logic                      flash_csb,
  output logic                      flash_clk,
  output logic                      flash_io0,
  input  logic                      flash_io1
);

  typedef enum logic [3:0] {
    ST_DISABLED, ST_INIT_CMD, ST_INIT_WAIT, ST_IDLE, ST_CMD,
    ST_ADDR, ST_DUMMY, ST_DATA, ST_DONE, ST_ABORT
  } state_t;

  localparam int          LW         = WORD_ADDR_BITS + 1;
  localparam logic [15:0] HALF_LAST  = 16'(SCLK_HALF - 1);
  localparam logic [15:0] INIT_LAST  = 16'(INIT_WAIT_CYCLES - 1);
  localparam logic [15:0] ABORT_LAST = 16'(2 * SCLK_HALF - 1);
  localparam logic [LW-1:0] LAST_WORD = LW'(PAGE_WORDS - 1);
`ifdef FLASH_LOADER_FAST_READ_EN
  localparam logic [7:0]  READ_CMD   = 8'h0B;
`else
  localparam logic [7:0]  READ_CMD   = 8'h03;
`endif

  state_t            r_state, w_next;
  logic              r_sclk;
  logic [15:0]       r_div;
  logic [15:0]       r_wait;
  logic [4:0]        r_bitcnt;
  logic [31:0]       r_txsr;
  logic [30:0]       r_rxsr;
  logic [23:0]       r_page;
  logic [LW-1:0]     r_load;
  logic              r_we;
  logic              r_done;
  logic [WORD_ADDR_BITS-1:0] r_sram_addr;
  logic [31:0]       r_sram_data;

  logic              w_shift, w_busy, w_tick, w_rise, w_fall;
  logic              w_accept, w_restart, w_word_done, w_enter_cmd, w_wait_state;
  logic [31:0]       w_rx_word, w_le_word;
  logic [23:0]       w_cmd_addr;

  assign w_shift      = (r_state == ST_INIT_CMD) || (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                        (r_state == ST_DUMMY) || (r_state == ST_DATA);
  assign w_busy       = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DUMMY) ||
                        (r_state == ST_DATA) || (r_state == ST_DONE) || (r_state == ST_ABORT);
  assign w_wait_state = (r_state == ST_INIT_WAIT) || (r_state == ST_DONE) || (r_state == ST_ABORT);
  assign w_tick       = w_shift && (r_div == HALF_LAST);
  assign w_rise       = w_tick && !r_sclk;
  assign w_fall       = w_tick && r_sclk;
  assign w_accept     = enable && start && (r_state == ST_IDLE);
  assign w_restart    = enable && start && w_busy;
  // A word completes on the rising SCLK that samples its 32nd bit; an abort in that cycle drops it.
  assign w_word_done  = enable && !start && (r_state == ST_DATA) && w_rise && (r_bitcnt == 5'd31);
  assign w_rx_word    = {r_rxsr, flash_io1};
  assign w_le_word    = {w_rx_word[7:0], w_rx_word[15:8], w_rx_word[23:16], w_rx_word[31:24]};
  assign w_enter_cmd  = (w_next == ST_CMD) && (r_state != ST_CMD);
  assign w_cmd_addr   = (r_state == ST_IDLE) ? pageAddress : r_page;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_DISABLED;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_DISABLED;
    end else if (w_restart) begin
      w_next = ST_ABORT;
    end else begin
      case (r_state)
        ST_DISABLED:  w_next = ST_INIT_CMD;
        ST_INIT_CMD:  if (w_fall && r_bitcnt == 5'd7) w_next = ST_INIT_WAIT;
        ST_INIT_WAIT: if (r_wait == INIT_LAST) w_next = ST_IDLE;
        ST_IDLE:      if (start) w_next = ST_CMD;
        ST_CMD:       if (w_fall && r_bitcnt == 5'd7) w_next = ST_ADDR;
`ifdef FLASH_LOADER_FAST_READ_EN
        ST_ADDR:      if (w_fall && r_bitcnt == 5'd23) w_next = ST_DUMMY;
        ST_DUMMY:     if (w_fall && r_bitcnt == 5'd7) w_next = ST_DATA;
`else
        ST_ADDR:      if (w_fall && r_bitcnt == 5'd23) w_next = ST_DATA;
`endif
        ST_DATA:      if (r_done) w_next = ST_DONE;
        ST_DONE:      if (r_wait == HALF_LAST) w_next = ST_IDLE;
        ST_ABORT:     if (r_wait == ABORT_LAST) w_next = ST_CMD;
        default:      w_next = ST_DISABLED;
      endcase
    end
  end

  always_comb begin
    flash_csb       = !w_shift;
    flash_clk       = r_sclk && w_shift;
    flash_io0       = r_txsr[31] && w_shift;
    busy            = w_busy;
    initialised     = w_busy || (r_state == ST_IDLE);
    loadAddress     = r_load;
    done            = r_done;
    sramWriteEnable = r_we;
    sramAddress     = r_sram_addr;
    sramData        = r_sram_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk      <= 1'b0;
      r_div       <= '0;
      r_wait      <= '0;
      r_bitcnt    <= '0;
      r_txsr      <= '0;
      r_rxsr      <= '0;
      r_page      <= '0;
      r_load      <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_sram_addr <= '0;
      r_sram_data <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;

      // SPI bit timing restarts from SCLK low on every state change
      if (w_next != r_state) begin
        r_div    <= '0;
        r_sclk   <= 1'b0;
        r_bitcnt <= '0;
        r_wait   <= '0;
      end else begin
        if (w_wait_state) r_wait <= r_wait + 16'd1;
        if (w_shift) begin
          r_div <= w_tick ? 16'd0 : r_div + 16'd1;
          if (w_tick) r_sclk <= !r_sclk;
          if (w_fall) r_bitcnt <= r_bitcnt + 5'd1;
        end
      end

      if (w_enter_cmd)                r_txsr <= {READ_CMD, w_cmd_addr};
      else if (r_state == ST_DISABLED) r_txsr <= {8'hAB, 24'h000000};
      else if (w_fall)                r_txsr <= {r_txsr[30:0], 1'b0};

      if (r_state == ST_DATA && w_rise) r_rxsr <= w_rx_word[30:0];

      if (w_accept || w_restart) r_page <= pageAddress;

      // SRAM write strobe one cycle after the last bit; count updates the cycle after that
      if (w_word_done) begin
        r_we        <= 1'b1;
        r_sram_addr <= r_load[WORD_ADDR_BITS-1:0];
        r_sram_data <= w_le_word;
        if (r_load == LAST_WORD) r_done <= 1'b1;
      end

      if (!enable || w_accept || w_restart) r_load <= '0;
      else if (r_we)                        r_load <= r_load + 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_page_loader.sv
// Bench for flash_page_loader: behavioural SPI flash model plus a queue scoreboard of SRAM writes.
module tb_flash_page_loader;

  logic        clk = 1'b0;
  logic        rst, enable, start;
  logic [23:0] pageAddress;
  logic        initialised, busy, done, sramWriteEnable;
  logic [9:0]  loadAddress;
  logic [8:0]  sramAddress;
  logic [31:0] sramData;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [40:0] exp_q[$];
  logic [40:0] e;
  int nwr = 0, ndone = 0, ntx = 0, rises = 0, last_rises = 0;
  logic [31:0] sr = '0, last_sr = '0, hdr = '0;

`ifdef FLASH_LOADER_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif

  flash_page_loader dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .pageAddress(pageAddress),
    .initialised(initialised), .busy(busy), .loadAddress(loadAddress), .done(done),
    .sramWriteEnable(sramWriteEnable), .sramAddress(sramAddress), .sramData(sramData),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] fb(input logic [23:0] a);
    return a[7:0] ^ (a[15:8] * 8'd37) ^ {a[19:16], a[23:20]} ^ 8'hC3;
  endfunction

  task automatic push_page(input logic [23:0] base);
    for (int i = 0; i < 512; i++) begin
      logic [23:0] a;
      a = base + 24'(4 * i);
      exp_q.push_back({9'(i), fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)});
    end
  endtask

  // SPI flash model: mode 0, command/address in, data out on falling SCLK
  always @(negedge flash_csb) begin
    rises = 0;
    sr    = '0;
  end
  always @(posedge flash_csb) begin
    ntx++;
    last_sr    = sr;
    last_rises = rises;
  end
  always @(posedge flash_clk) if (flash_csb === 1'b0) begin
    if (rises < 32) sr = {sr[30:0], flash_io0};
    rises++;
    if (rises == 32) hdr = sr;
  end
  always @(negedge flash_clk) if (flash_csb === 1'b0) begin
    int ds, k;
    logic [7:0] b;
    ds = (sr[31:24] == 8'h0B) ? 40 : 32;
    if (rises >= ds) begin
      k = rises - ds;
      b = fb(sr[23:0] + 24'(k / 8));
      flash_io1 = b[3'(7 - (k % 8))];
    end
  end

  always @(negedge clk) if (rst === 1'b1 && sramWriteEnable === 1'b1) begin
    nwr++;
    if (exp_q.size() == 0) begin
      check("write_allowed", 64'(sramWriteEnable), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check("sram_addr", 64'(sramAddress), 64'(e[40:32]));
      check("sram_data", 64'(sramData), 64'(e[31:0]));
      check("load_addr_at_write", 64'(loadAddress), 64'(e[40:32]));
    end
  end

  always @(negedge clk) if (rst === 1'b1 && done === 1'b1) begin
    ndone++;
    check("done_with_last_write", 64'({sramWriteEnable, sramAddress}), 64'({1'b1, 9'd511}));
  end

  initial begin
    int cyc, hi, ntx0, nwr0;
    bit pulsed;
    rst = 1'b0; enable = 1'b0; start = 1'b0; pageAddress = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_spi_pins", 64'({flash_csb, flash_clk, flash_io0}), 64'(3'b100));
    check("rst_status", 64'({initialised, busy, done, sramWriteEnable}), 64'(0));
    check("rst_load_addr", 64'(loadAddress), 64'(0));
    check("rst_sram_bus", 64'({sramAddress, sramData}), 64'(0));

    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (flash_csb !== 1'b1) cyc++;
    end
    check("disabled_csb_low_cycles", 64'(cyc), 64'(0));

    // Init sequence; start pulses during INIT_CMD and INIT_WAIT must be ignored
    ntx0 = ntx; enable = 1'b1; pageAddress = 24'h123400;
    pulsed = 1'b0; cyc = 0; hi = 0;
    while (initialised !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);
      if (ntx == ntx0 + 1 && initialised !== 1'b1) begin
        hi++;
        if (!pulsed) begin start = 1'b1; pulsed = 1'b1; end
      end
    end
    start = 1'b0;
    check("init_reached", 64'(initialised), 64'(1));
    check("init_transactions", 64'(ntx - ntx0), 64'(1));
    check("init_sclk_pulses", 64'(last_rises), 64'(8));
    check("init_cmd_byte", 64'(last_sr[7:0]), 64'(8'hAB));
    check("init_wait_cycles", 64'(hi), 64'(4));
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (flash_csb !== 1'b1 || busy !== 1'b0) cyc++;
    end
    check("ignored_start_no_activity", 64'(cyc), 64'(0));

    // Full load of page 0
    push_page(24'h000000);
    nwr0 = nwr; pageAddress = 24'h000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("load_cleared_on_start", 64'(loadAddress), 64'(0));
    cyc = 0;
    while (ndone == 0 && cyc < 40000) begin @(negedge clk); cyc++; end
    check("page0_done_seen", 64'(ndone), 64'(1));
    repeat (4) @(negedge clk);
    check("page0_busy_fell", 64'(busy), 64'(0));
    check("page0_load_addr_full", 64'(loadAddress), 64'(512));
    check("page0_write_count", 64'(nwr - nwr0), 64'(512));
    check("page0_header", 64'(hdr), 64'({EXP_CMD, 24'h000000}));
    check("page0_queue_drained", 64'(exp_q.size()), 64'(0));
    check("page0_csb_released", 64'(flash_csb), 64'(1));

    // Mid-load restart at loadAddress 37
    push_page(24'h000000);
    nwr0 = nwr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (loadAddress !== 10'd37 && cyc < 5000) begin @(negedge clk); cyc++; end
    check("restart_point_reached", 64'(loadAddress), 64'(37));
    exp_q.delete();
    push_page(24'h000800);
    pageAddress = 24'h000800; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_load_cleared", 64'(loadAddress), 64'(0));
    check("restart_sclk_low", 64'(flash_clk), 64'(0));
    hi = 0; cyc = 0;
    while (flash_csb === 1'b1 && cyc < 100) begin hi++; @(negedge clk); cyc++; end
    check("restart_csb_gap_min", 64'(hi >= 2), 64'(1));
    check("restart_csb_reasserted", 64'(flash_csb), 64'(0));
    cyc = 0;
    while (loadAddress !== 10'd100 && cyc < 10000) begin @(negedge clk); cyc++; end
    check("second_point_reached", 64'(loadAddress), 64'(100));
    check("restart_header", 64'(hdr), 64'({EXP_CMD, 24'h000800}));
    check("no_done_from_abort", 64'(ndone), 64'(1));
    check("restart_write_count", 64'(nwr - nwr0), 64'(137));

    // Disable mid-load at loadAddress 100
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk);
    check("disable_spi_pins", 64'({flash_csb, flash_clk}), 64'(2'b10));
    check("disable_status", 64'({busy, initialised}), 64'(0));
    check("disable_load_cleared", 64'(loadAddress), 64'(0));
    nwr0 = nwr;
    repeat (300) @(negedge clk);
    check("disabled_no_writes", 64'(nwr - nwr0), 64'(0));

    // Re-enable repeats the release-power-down sequence
    ntx0 = ntx; enable = 1'b1; cyc = 0;
    while (initialised !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    check("reinit_reached", 64'(initialised), 64'(1));
    check("reinit_transactions", 64'(ntx - ntx0), 64'(1));
    check("reinit_sclk_pulses", 64'(last_rises), 64'(8));
    check("reinit_cmd_byte", 64'(last_sr[7:0]), 64'(8'hAB));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
